// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared write-back select and load-size constants
package mips_pkg;

  // Write-back source selects; 2'b11 is reserved and flagged as illegal
  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_MEM  = 2'b01;
  localparam logic [1:0] WB_SEL_LINK = 2'b10;
  localparam logic [1:0] WB_SEL_ILL  = 2'b11;

  // Load sizes; 2'b11 behaves as a full word
  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

endpackage

// File: rtl/wb_select_stage_if.sv
// rtl/wb_select_stage_if.sv - MEM-side inputs and register-file outputs of the write-back stage
interface wb_select_stage_if #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ERR_CNT_W  = 8
);
  localparam int OFF_W = $clog2(WIDTH / 8);

  logic                  stall;
  logic                  flush;
  logic                  in_valid;
  logic [1:0]            in_sel;
  logic [WIDTH-1:0]      in_alu;
  logic [WIDTH-1:0]      in_mem;
  logic [WIDTH-1:0]      in_pc_plus4;
  logic [1:0]            in_mem_size;
  logic                  in_mem_signed;
  logic [OFF_W-1:0]      in_byte_off;
  logic [REG_ADDR_W-1:0] in_rd;
  logic                  in_reg_write;

  logic                  out_valid;
  logic                  out_wen;
  logic [REG_ADDR_W-1:0] out_waddr;
  logic [WIDTH-1:0]      out_wdata;
  logic                  sel_err;
  logic [ERR_CNT_W-1:0]  err_count;

  // Upstream pipeline side: drives the MEM-stage results, observes write-back
  modport master (
    output stall, flush, in_valid, in_sel, in_alu, in_mem, in_pc_plus4,
           in_mem_size, in_mem_signed, in_byte_off, in_rd, in_reg_write,
    input  out_valid, out_wen, out_waddr, out_wdata, sel_err, err_count
  );

  // Stage side
  modport slave (
    input  stall, flush, in_valid, in_sel, in_alu, in_mem, in_pc_plus4,
           in_mem_size, in_mem_signed, in_byte_off, in_rd, in_reg_write,
    output out_valid, out_wen, out_waddr, out_wdata, sel_err, err_count
  );

endinterface

// File: rtl/load_extend.sv
// rtl/load_extend.sv - combinational sub-word load lane extraction with sign/zero extension
module load_extend
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OFF_W = $clog2(WIDTH / 8)
) (
  input  logic [WIDTH-1:0] i_mem,
  input  logic [1:0]       i_size,
  input  logic             i_signed,
  input  logic [OFF_W-1:0] i_off,
  output logic [WIDTH-1:0] o_data
);

  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_word;
  logic [OFF_W-1:0] w_half_off;

  // Halfword loads are treated as aligned: offset bit 0 is dropped
  assign w_half_off = {i_off[OFF_W-1:1], 1'b0};
  assign w_byte     = i_mem[{i_off, 3'b000} +: 8];
  assign w_half     = i_mem[{w_half_off, 3'b000} +: 16];
  assign w_word     = i_mem[31:0];

  // Fill with the extension bit first, then overlay the extracted lane
  always_comb begin
    o_data = '0;
    case (i_size)
      MEM_BYTE: begin
        o_data       = {WIDTH{i_signed & w_byte[7]}};
        o_data[7:0]  = w_byte;
      end
      MEM_HALF: begin
        o_data       = {WIDTH{i_signed & w_half[15]}};
        o_data[15:0] = w_half;
      end
      MEM_WORD: begin
        o_data       = {WIDTH{i_signed & w_word[31]}};
        o_data[31:0] = w_word;
      end
      default: begin
        o_data       = {WIDTH{i_signed & w_word[31]}};
        o_data[31:0] = w_word;
      end
    endcase
  end

endmodule

// File: rtl/wb_select_stage.sv
// rtl/wb_select_stage.sv - registered write-back source select with illegal-select tracking
module wb_select_stage
  import mips_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5,
  parameter int LINK_REG   = 31,
  parameter int ERR_CNT_W  = 8
) (
  input logic             clk,
  input logic             reset,
  wb_select_stage_if.slave bus
);

  localparam int OFF_W = $clog2(WIDTH / 8);
  localparam logic [REG_ADDR_W-1:0] LINK_ADDR = REG_ADDR_W'(LINK_REG);

  logic [WIDTH-1:0]      w_load_data;
  logic [WIDTH-1:0]      w_sel_data;
  logic [REG_ADDR_W-1:0] w_sel_addr;
  logic                  w_capture_valid;
  logic                  w_illegal;
  logic                  w_capture_wen;

  logic                  r_valid;
  logic                  r_wen;
  logic [REG_ADDR_W-1:0] r_waddr;
  logic [WIDTH-1:0]      r_wdata;
  logic                  r_sel_err;
  logic [ERR_CNT_W-1:0]  r_err_count;

  load_extend #(
    .WIDTH (WIDTH),
    .OFF_W (OFF_W)
  ) u_load_extend (
    .i_mem    (bus.in_mem),
    .i_size   (bus.in_mem_size),
    .i_signed (bus.in_mem_signed),
    .i_off    (bus.in_byte_off),
    .o_data   (w_load_data)
  );

  assign w_capture_valid = bus.in_valid & ~bus.flush;
  assign w_illegal       = (bus.in_sel == WB_SEL_ILL);
  assign w_sel_addr      = (bus.in_sel == WB_SEL_LINK) ? LINK_ADDR : bus.in_rd;
  // Register 0 is hard-wired, so a write to it is suppressed while data still updates
  assign w_capture_wen   = w_capture_valid & bus.in_reg_write & ~w_illegal &
                           (w_sel_addr != '0);

  // Write-back source mux; the reserved select drives zero data
  always_comb begin
    w_sel_data = '0;
    case (bus.in_sel)
      WB_SEL_ALU:  w_sel_data = bus.in_alu;
      WB_SEL_MEM:  w_sel_data = w_load_data;
      WB_SEL_LINK: w_sel_data = bus.in_pc_plus4;
      default:     w_sel_data = '0;
    endcase
  end

  // Stage register: capture when not stalled; a flush during stall kills only valid/wen
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (!bus.stall) begin
      r_valid <= w_capture_valid;
      r_wen   <= w_capture_wen;
      r_waddr <= w_sel_addr;
      r_wdata <= w_sel_data;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
      r_wen   <= 1'b0;
    end
  end

  // Sticky flag and saturating counter, advanced only when an illegal select is captured
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel_err   <= 1'b0;
      r_err_count <= '0;
    end else if (!bus.stall && w_capture_valid && w_illegal) begin
      r_sel_err <= 1'b1;
      if (r_err_count != '1) begin
        r_err_count <= r_err_count + ERR_CNT_W'(1);
      end
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.out_wen   = r_wen;
  assign bus.out_waddr = r_waddr;
  assign bus.out_wdata = r_wdata;
  assign bus.sel_err   = r_sel_err;
  assign bus.err_count = r_err_count;

endmodule

// File: tb/tb_wb_select_stage.sv
// tb/tb_wb_select_stage.sv - self-checking bench for wb_select_stage
module tb_wb_select_stage;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  wb_select_stage_if #(.WIDTH(32), .REG_ADDR_W(5), .ERR_CNT_W(8)) bus ();

  wb_select_stage #(
    .WIDTH      (32),
    .REG_ADDR_W (5),
    .LINK_REG   (31),
    .ERR_CNT_W  (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed as {valid, wen, waddr, wdata, sel_err, err_count}
  wire [47:0] obs = {bus.out_valid, bus.out_wen, bus.out_waddr, bus.out_wdata,
                     bus.sel_err, bus.err_count};

  // Reference model state
  logic        m_valid, m_wen, m_err;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          m_cnt;
  wire  [47:0] mdl = {m_valid, m_wen, m_waddr, m_wdata, m_err, 8'(m_cnt)};

  function automatic logic [31:0] ref_extract(input logic [31:0] mem, input logic [1:0] size,
                                              input int off, input logic sgn);
    logic [31:0] lane;
    case (size)
      2'd0: begin
        lane = (mem >> (8 * off)) & 32'hFF;
        if (sgn && lane >= 32'h80) lane = lane | 32'hFFFF_FF00;
      end
      2'd1: begin
        lane = (mem >> (8 * (off & 2))) & 32'hFFFF;
        if (sgn && lane >= 32'h8000) lane = lane | 32'hFFFF_0000;
      end
      default: lane = mem;
    endcase
    return lane;
  endfunction

  task automatic model_edge();
    logic v;
    logic [4:0] a;
    if (reset) begin
      m_valid = 0; m_wen = 0; m_waddr = 0; m_wdata = 0; m_err = 0; m_cnt = 0;
    end else if (!bus.stall) begin
      v = bus.in_valid && !bus.flush;
      a = (bus.in_sel == 2'd2) ? 5'd31 : bus.in_rd;
      case (bus.in_sel)
        2'd0: m_wdata = bus.in_alu;
        2'd1: m_wdata = ref_extract(bus.in_mem, bus.in_mem_size, int'(bus.in_byte_off),
                                    bus.in_mem_signed);
        2'd2: m_wdata = bus.in_pc_plus4;
        default: m_wdata = 0;
      endcase
      m_valid = v;
      m_waddr = a;
      m_wen   = v && bus.in_reg_write && bus.in_sel != 2'd3 && a != 0;
      if (v && bus.in_sel == 2'd3) begin
        m_err = 1;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
      end
    end else if (bus.flush) begin
      m_valid = 0;
      m_wen   = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic randomize_inputs(input bit allow_illegal);
    bus.in_valid      = 1'($urandom);
    bus.in_sel        = allow_illegal ? 2'($urandom) : 2'($urandom_range(0, 2));
    bus.in_alu        = $urandom;
    bus.in_mem        = $urandom;
    bus.in_pc_plus4   = $urandom;
    bus.in_mem_size   = 2'($urandom);
    bus.in_mem_signed = 1'($urandom);
    bus.in_byte_off   = 2'($urandom);
    bus.in_rd         = 5'($urandom);
    bus.in_reg_write  = 1'($urandom);
  endtask

  task automatic test_reset();
    logic [47:0] exp;
    bus.stall = 0; bus.flush = 0;
    randomize_inputs(0);
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (obs !== 48'h0) begin
        miscompares++;
        $display("FAIL reset_hold: got %h required %h", obs, 48'h0);
      end
    end
    // Reset while stalled still clears; stall keeps the cleared state after release
    bus.stall = 1;
    tick();
    reset = 0;
    tick();
    vectors++;
    if (obs !== 48'h0) begin
      miscompares++;
      $display("FAIL reset_then_stall: got %h required %h", obs, 48'h0);
    end
    bus.stall = 0;
    bus.in_valid = 1; bus.in_sel = 2'd0; bus.in_alu = 32'h55; bus.in_rd = 5'd3;
    bus.in_reg_write = 1;
    tick();
    exp = {1'b1, 1'b1, 5'd3, 32'h55, 1'b0, 8'd0};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL first_capture: got %h required %h", obs, exp);
    end
  endtask

  task automatic test_link();
    logic [47:0] exp;
    bus.in_valid = 1; bus.in_sel = 2'd2; bus.in_pc_plus4 = 32'h0040_0008;
    bus.in_rd = 5'd5; bus.in_reg_write = 1;
    tick();
    exp = {1'b1, 1'b1, 5'd31, 32'h0040_0008, 1'b0, 8'd0};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL link_force: got %h required %h", obs, exp);
    end
  endtask

  task automatic test_loads();
    logic [1:0]  sizes [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd3};
    logic [1:0]  offs  [5] = '{2'd3, 2'd3, 2'd2, 2'd3, 2'd1};
    logic        sgns  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] wants [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80F1,
                               32'h0000_80F1, 32'h80F1_7F22};
    bus.in_valid = 1; bus.in_sel = 2'd1; bus.in_mem = 32'h80F1_7F22;
    bus.in_rd = 5'd9; bus.in_reg_write = 1;
    for (int i = 0; i < 5; i++) begin
      bus.in_mem_size = sizes[i]; bus.in_byte_off = offs[i]; bus.in_mem_signed = sgns[i];
      tick();
      vectors++;
      if (obs !== {1'b1, 1'b1, 5'd9, wants[i], 1'b0, 8'd0}) begin
        miscompares++;
        $display("FAIL load_%0d: got wdata %h wen %b required wdata %h wen 1",
                 i, bus.out_wdata, bus.out_wen, wants[i]);
      end
    end
  endtask

  task automatic test_stall_flush();
    logic [47:0] exp;
    bus.in_valid = 1; bus.in_sel = 2'd0; bus.in_alu = 32'h1234; bus.in_rd = 5'd7;
    bus.in_reg_write = 1;
    tick();
    exp = {1'b1, 1'b1, 5'd7, 32'h1234, 1'b0, 8'd0};
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs(1);
      tick();
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL stall_hold_%0d: got %h required %h", i, obs, exp);
      end
    end
    bus.flush = 1;
    tick();
    exp = {1'b0, 1'b0, 5'd7, 32'h1234, 1'b0, 8'd0};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL flush_in_stall: got %h required %h", obs, exp);
    end
    bus.flush = 0;
    bus.stall = 0;
  endtask

  task automatic test_reg0();
    logic [47:0] exp;
    bus.in_valid = 1; bus.in_sel = 2'd0; bus.in_alu = 32'hDEAD; bus.in_rd = 5'd0;
    bus.in_reg_write = 1;
    tick();
    exp = {1'b1, 1'b0, 5'd0, 32'hDEAD, 1'b0, 8'd0};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL reg0_write: got %h required %h", obs, exp);
    end
  endtask

  task automatic test_illegal_saturation();
    logic [47:0] exp;
    reset = 1;
    tick();
    reset = 0;
    bus.in_valid = 1; bus.in_sel = 2'd3; bus.in_rd = 5'd4; bus.in_reg_write = 1;
    bus.in_alu = 32'hFFFF_FFFF;
    for (int i = 1; i <= 260; i++) begin
      tick();
      exp = {1'b1, 1'b0, 5'd4, 32'h0, 1'b1, 8'((i < 255) ? i : 255)};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL illegal_cycle_%0d: got %h required %h", i, obs, exp);
      end
    end
    reset = 1;
    tick();
    vectors++;
    if ({bus.sel_err, bus.err_count} !== 9'h0) begin
      miscompares++;
      $display("FAIL illegal_reset: got err %b count %0d required 0 0",
               bus.sel_err, bus.err_count);
    end
    reset = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      reset     = ($urandom_range(0, 39) == 0);
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.flush = ($urandom_range(0, 7) == 0);
      randomize_inputs(1);
      tick();
      vectors++;
      if (obs !== mdl) begin
        miscompares++;
        $display("FAIL random_%0d: got %h required %h", i, obs, mdl);
      end
    end
    reset = 0; bus.stall = 0; bus.flush = 0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1;
    m_valid = 0; m_wen = 0; m_waddr = 0; m_wdata = 0; m_err = 0; m_cnt = 0;
    test_reset();
    test_link();
    test_loads();
    test_stall_flush();
    test_reg0();
    test_illegal_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
